// File: rtl/instruction_pkg.sv
// Shared types and constants for the instruction fetch path.
// Contents: XLEN, INST_BYTES, fetch_entry_t (pc + instruction word), align_pc().
package instruction_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // No compressed instructions: targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response,
// and the instruction output toward execute.
// master: the fetch unit side. slave: the environment (execute + imem) side.
interface fetch_unit_if;
  import instruction_pkg::*;

  logic            redirect_v_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            inst_ready_i;
  logic            inst_v_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] inst_o;

  modport master (
    input  redirect_v_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           inst_ready_i,
    output imem_req_o, imem_addr_o, inst_v_o, pc_o, inst_o
  );

  modport slave (
    output redirect_v_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_v_o, pc_o, inst_o
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush.
// Ports: clk, reset (sync, active-high), flush_i, push_i/data_i, pop_i,
//        data_o (head), full_o, empty_o, count_o.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer/count next state; flush discards all entries.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = ptr_inc(wptr_q);
      if (pop_i)  rptr_d = ptr_inc(rptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) store_q[wptr_q] <= data_i;
  end

  assign data_o  = store_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited requests
// to instruction memory, in-order response pairing with request PCs, an
// instruction queue toward execute, and redirect with stale-response dropping.
// Ports: clk, reset (sync, active-high), bus (fetch_unit_if.master).
module fetch_unit
  import instruction_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t     iq_head, iq_wdata;
  logic             iq_full, iq_empty;
  logic [CNT_W-1:0] iq_count;
  logic [31:0]      pq_head;
  logic             pq_full, pq_empty;
  logic [CNT_W-1:0] pq_count;

  logic inst_v_c, pop_c, credit_c, req_c, accept_c, resp_c, push_c;

  // Handshake decode. Outstanding requests are exactly the PC-queue entries.
  always_comb begin
    inst_v_c = !reset && !iq_empty && !bus.redirect_v_i;
    pop_c    = inst_v_c && bus.inst_ready_i;
    credit_c = (SUM_W'(iq_count) + SUM_W'(pq_count) - SUM_W'(pop_c)) < SUM_W'(DEPTH);
    req_c    = !reset && !bus.redirect_v_i && credit_c;
    accept_c = req_c && bus.imem_gnt_i;
    resp_c   = !reset && bus.imem_rvalid_i;
    push_c   = resp_c && (drop_cnt_q == '0) && !bus.redirect_v_i;
    iq_wdata = '{pc: pq_head, inst: bus.imem_rdata_i};
  end

  // Fetch PC and drop counter next state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (accept_c) fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
    if (bus.redirect_v_i) begin
      fetch_pc_d = align_pc(bus.redirect_pc_i);
      // No request is accepted in a redirect cycle, so every request still in
      // flight after this cycle's response is wrong-path.
      drop_cnt_d = pq_count - CNT_W'(resp_c);
    end else if (resp_c && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Instruction queue toward execute; flushed on redirect.
  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_inst_q (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.redirect_v_i),
    .push_i  (push_c),
    .data_i  (iq_wdata),
    .pop_i   (pop_c),
    .data_o  (iq_head),
    .full_o  (iq_full),
    .empty_o (iq_empty),
    .count_o (iq_count)
  );

  // In-flight request PCs; never flushed because stale responses still return.
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_q (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (accept_c),
    .data_i  (fetch_pc_q),
    .pop_i   (resp_c),
    .data_o  (pq_head),
    .full_o  (pq_full),
    .empty_o (pq_empty),
    .count_o (pq_count)
  );

  assign bus.imem_req_o  = req_c;
  assign bus.imem_addr_o = fetch_pc_q;
  assign bus.inst_v_o    = inst_v_c;
  assign bus.pc_o        = iq_head.pc;
  assign bus.inst_o      = iq_head.inst;

  // Credit rule guarantees neither queue over- or underflows.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push_c && iq_full));
      assert (!(accept_c && pq_full));
      assert (!(resp_c && pq_empty));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized
// latency/redirect traffic checked against an architectural-path model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic clk;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  // Stimulus knobs.
  logic        drv_gnt, drv_ready, drv_redirect;
  logic [31:0] drv_tgt;
  int          lat_min, lat_max;

  // Sampled DUT outputs for the current cycle.
  logic        s_req, s_v;
  logic [31:0] s_addr, s_pc, s_inst;

  // Memory model and architectural reference.
  mreq_t       mem_q[$];
  int          last_due;
  logic [31:0] exp_fetch, exp_pc;
  int          delivered;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at negedge, score, update models.
  task automatic tick();
    logic rv;
    int   lat, due;
    rv = 1'b0;
    if (!reset && mem_q.size() != 0) rv = (mem_q[0].due <= cyc);
    bus.imem_rvalid_i = rv;
    if (rv) bus.imem_rdata_i = mem_word(mem_q[0].addr);
    else    bus.imem_rdata_i = 32'h0;
    bus.imem_gnt_i    = drv_gnt;
    bus.redirect_v_i  = drv_redirect;
    bus.redirect_pc_i = drv_tgt;
    bus.inst_ready_i  = drv_ready;
    @(negedge clk);
    s_req  = bus.imem_req_o;
    s_addr = bus.imem_addr_o;
    s_v    = bus.inst_v_o;
    s_pc   = bus.pc_o;
    s_inst = bus.inst_o;
    if (reset) begin
      chk("rst_req", 32'(s_req), 32'h0);
      chk("rst_inst_v", 32'(s_v), 32'h0);
      mem_q.delete();
      last_due  = 0;
      exp_fetch = RESET_PC;
      exp_pc    = RESET_PC;
    end else begin
      if (drv_redirect) begin
        chk("redirect_inst_v", 32'(s_v), 32'h0);
        chk("redirect_req", 32'(s_req), 32'h0);
      end
      if (s_req) chk("req_addr", s_addr, exp_fetch);
      if (s_v) begin
        chk("out_pc", s_pc, exp_pc);
        chk("out_inst", s_inst, mem_word(exp_pc));
        if (drv_ready) begin
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      if (s_req && drv_gnt) begin
        lat = int'($urandom_range(lat_max, lat_min));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        mem_q.push_back('{addr: s_addr, due: due});
        last_due  = due;
        exp_fetch = exp_fetch + 32'd4;
      end
      if (rv) void'(mem_q.pop_front());
      if (drv_redirect) begin
        exp_fetch = {drv_tgt[31:2], 2'b00};
        exp_pc    = exp_fetch;
      end
      chk("credit_bound", 32'(((exp_fetch - exp_pc) >> 2) <= 32'(DEPTH)), 32'h1);
      chk("outstanding_bound", 32'(mem_q.size() <= DEPTH), 32'h1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] a0, a1, a2, a3, head;
    int          g, d0;
    logic        found;

    reset = 1'b1;
    drv_gnt = 1'b1; drv_ready = 1'b1; drv_redirect = 1'b0; drv_tgt = 32'h0;
    lat_min = 1; lat_max = 1; delivered = 0; last_due = 0;
    exp_fetch = RESET_PC; exp_pc = RESET_PC;
    repeat (3) tick();

    // Reset release, 1-cycle memory: sequential addresses, delivery at grant+2.
    reset = 1'b0;
    tick();
    chk("t1_req0", 32'(s_req), 32'h1);
    chk("t1_addr0", s_addr, RESET_PC);
    chk("t1_v0", 32'(s_v), 32'h0);
    tick();
    chk("t1_addr1", s_addr, RESET_PC + 32'd4);
    chk("t1_v1", 32'(s_v), 32'h0);
    tick();
    chk("t1_addr2", s_addr, RESET_PC + 32'd8);
    chk("t1_v2", 32'(s_v), 32'h1);
    chk("t1_pc2", s_pc, RESET_PC);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_stream_v", 32'(s_v), 32'h1);
    end

    // Redirect to 0x100 with two requests in flight (2-cycle memory).
    lat_min = 2; lat_max = 2;
    tick(); tick();
    drv_redirect = 1'b1; drv_tgt = 32'h0000_0100;
    tick();
    drv_redirect = 1'b0; lat_min = 1; lat_max = 1;
    tick();
    chk("t2_req", 32'(s_req), 32'h1);
    chk("t2_addr", s_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_v) found = 1'b1;
    end
    chk("t2_delivered", 32'(found), 32'h1);
    chk("t2_first_pc", s_pc, 32'h0000_0100);
    repeat (6) tick();

    // Unaligned redirect target, 1-cycle memory: target delivered at t+3.
    drv_redirect = 1'b1; drv_tgt = 32'h0000_0102;
    tick();
    drv_redirect = 1'b0;
    tick();
    chk("t3_req", 32'(s_req), 32'h1);
    chk("t3_addr", s_addr, 32'h0000_0100);
    tick();
    chk("t3_v_t2", 32'(s_v), 32'h0);
    tick();
    chk("t3_v_t3", 32'(s_v), 32'h1);
    chk("t3_pc_t3", s_pc, 32'h0000_0100);
    repeat (4) tick();

    // Back-pressure: head stable, requests stop within the credit limit.
    drv_ready = 1'b0; g = 0; head = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_req && drv_gnt) g++;
      chk("bp_v", 32'(s_v), 32'h1);
      if (i == 0) head = s_pc;
      else        chk("bp_head", s_pc, head);
    end
    chk("bp_grants", 32'(g <= DEPTH), 32'h1);
    chk("bp_req_off", 32'(s_req), 32'h0);
    drv_ready = 1'b1;
    d0 = delivered;
    repeat (6) tick();
    chk("bp_resume", 32'(delivered - d0 >= 4), 32'h1);

    // Grant pattern 1,0,0,1: address held while grant is withheld.
    drv_gnt = 1'b1; tick(); a0 = s_addr;
    drv_gnt = 1'b0; tick(); a1 = s_addr;
    chk("gnt_req1", 32'(s_req), 32'h1);
    tick(); a2 = s_addr;
    chk("gnt_req2", 32'(s_req), 32'h1);
    drv_gnt = 1'b1; tick(); a3 = s_addr;
    chk("gnt_req3", 32'(s_req), 32'h1);
    chk("gnt_adv", a1, a0 + 32'd4);
    chk("gnt_hold1", a2, a1);
    chk("gnt_hold2", a3, a2);
    repeat (6) tick();

    // Address wrap at the top of memory.
    drv_redirect = 1'b1; drv_tgt = 32'hFFFF_FFF8;
    tick();
    drv_redirect = 1'b0;
    tick(); chk("wrap_a0", s_addr, 32'hFFFF_FFF8);
    tick(); chk("wrap_a1", s_addr, 32'hFFFF_FFFC);
    tick(); chk("wrap_a2", s_addr, 32'h0000_0000);
    repeat (6) tick();

    // Randomized latency, grant, ready and redirects.
    lat_min = 1; lat_max = 3;
    d0 = delivered;
    for (int i = 0; i < 400; i++) begin
      drv_redirect = ($urandom_range(99) < 20);
      drv_tgt      = $urandom;
      drv_gnt      = ($urandom_range(3) != 0);
      drv_ready    = ($urandom_range(4) != 0);
      tick();
    end
    chk("rand_progress", 32'(delivered - d0 > 50), 32'h1);

    // Mid-stream reset: outputs drop, fetch restarts at RESET_PC.
    drv_redirect = 1'b0; drv_gnt = 1'b1; drv_ready = 1'b1;
    lat_min = 1; lat_max = 1;
    repeat (8) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst2_req", 32'(s_req), 32'h1);
    chk("rst2_addr", s_addr, RESET_PC);
    tick(); tick();
    chk("rst2_v", 32'(s_v), 32'h1);
    chk("rst2_pc", s_pc, RESET_PC);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
